// File: rtl/reg_scoreboard_pkg.sv
// Shared pipeline definitions for the register scoreboard: entry record,
// width helpers and stage-index constants.
package reg_scoreboard_pkg;

    localparam int MAX_ADDR_W = 16;
    localparam int MAX_DEPTH  = 8;
    localparam int STAGE_EX   = 0;  // youngest tracked stage
    localparam int STAGE_LATE = 1;  // first stage where a late result exists

    typedef struct packed {
        logic                  valid;
        logic                  late;
        logic [MAX_ADDR_W-1:0] waddr;
    } sb_entry_t;

    function automatic int stage_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int count_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sb_match.sv
// Per-read-port hazard match: finds the youngest valid entry writing the
// source register and reports its stage index and late flag.
module sb_match
    import reg_scoreboard_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 3,
    parameter int SW     = stage_w(DEPTH)
) (
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    input  sb_entry_t [DEPTH-1:0] entries,
    output logic                  hit,
    output logic [SW-1:0]         stage,
    output logic                  late
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        hit   = 1'b0;
        stage = '0;
        late  = 1'b0;
        // Scan oldest to youngest so the youngest match overwrites older ones.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rd_en && (rd_addr != '0) && entries[k].valid &&
                (entries[k].waddr == MAX_ADDR_W'(rd_addr))) begin
                hit   = 1'b1;
                stage = SW'(k);
                late  = entries[k].late;
            end
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// In-order GPR scoreboard tracking DEPTH stages between decode and writeback.
// Define SCOREBOARD_FWD_EN to report forwarding sources and stall only on late results.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter  int ADDR_W     = 5,
    parameter  int DEPTH      = 3,
    parameter  int READ_PORTS = 2,
    localparam int SW         = stage_w(DEPTH),
    localparam int CW         = count_w(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid_i,
    input  logic                       issue_we_i,
    input  logic [ADDR_W-1:0]          issue_waddr_i,
    input  logic                       issue_late_i,
    input  logic [READ_PORTS-1:0]        rd_en_i,
    input  logic [READ_PORTS*ADDR_W-1:0] rd_addr_i,
    input  logic                       hold_i,
    input  logic                       flush_i,
    output logic                       stall_o,
    output logic [READ_PORTS-1:0]      fwd_hit_o,
    output logic [READ_PORTS*SW-1:0]   fwd_stage_o,
    output logic [CW-1:0]              pending_o
);

    sb_entry_t [DEPTH-1:0]         entry_q, entry_d;
    logic [CW-1:0]                 pending_q, pending_d;
    logic [READ_PORTS-1:0]         hit, late_hit;
    logic [READ_PORTS-1:0][SW-1:0] hit_stage;

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        sb_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SW(SW)) u_match (
            .rd_en   (rd_en_i[p]),
            .rd_addr (rd_addr_i[p*ADDR_W +: ADDR_W]),
            .entries (entry_q),
            .hit     (hit[p]),
            .stage   (hit_stage[p]),
            .late    (late_hit[p])
        );
    end

`ifdef SCOREBOARD_FWD_EN
    // Only a late result still sitting in EX cannot be forwarded.
    always_comb begin
        stall_o     = 1'b0;
        fwd_hit_o   = hit;
        fwd_stage_o = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            fwd_stage_o[p*SW +: SW] = hit_stage[p];
            if (issue_valid_i && hit[p] && late_hit[p] && (hit_stage[p] == SW'(STAGE_EX)))
                stall_o = 1'b1;
        end
    end
`else
    logic unused_fwd_info;
    assign unused_fwd_info = ^{late_hit, hit_stage};
    assign stall_o         = issue_valid_i && (|hit);
    assign fwd_hit_o       = '0;
    assign fwd_stage_o     = '0;
`endif

    always_comb begin
        entry_d[0] = '{valid: issue_valid_i && issue_we_i && (issue_waddr_i != '0) && !stall_o,
                       late:  issue_late_i,
                       waddr: MAX_ADDR_W'(issue_waddr_i)};
        for (int k = 1; k < DEPTH; k++)
            entry_d[k] = entry_q[k-1];
        pending_d = '0;
        for (int k = 0; k < DEPTH; k++)
            pending_d = pending_d + CW'(entry_d[k].valid);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: entries are plain flops (not a RAM), so reset clears every one of them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q   <= '0;
            pending_q <= '0;
        end else if (flush_i) begin
            entry_q   <= '0;
            pending_q <= '0;
        end else if (!hold_i) begin
            entry_q   <= entry_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, register address width.
REQ-002 SHALL have parameter DEPTH, default 3, tracked stages between decode and writeback (EX..MEM/WB); legal range 1..8.
REQ-003 SHALL have parameter READ_PORTS, default 2, decode source-operand ports; legal range 1..4.
REQ-004 SHALL define SW = max(1, clog2(DEPTH)) as the stage-index width.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port issue_valid_i  input  1  decode presents an instruction this cycle.
REQ-008 SHALL have port issue_we_i  input  1  instruction writes a GPR.
REQ-009 SHALL have port issue_waddr_i  input  ADDR_W  destination register.
REQ-010 SHALL have port issue_late_i  input  1  result not ready until the entry's second tracked stage (load/multicycle).
REQ-011 SHALL have port rd_en_i  input  READ_PORTS  per-port read enable.
REQ-012 SHALL have port rd_addr_i  input  READ_PORTS*ADDR_W  per-port source address, port p at bits [p*ADDR_W +: ADDR_W].
REQ-013 SHALL have port hold_i  input  1  external pipeline freeze.
REQ-014 SHALL have port flush_i  input  1  discard all in-flight entries.
REQ-015 SHALL have port stall_o  output  1  decode must not advance this cycle.
REQ-016 SHALL have port fwd_hit_o  output  READ_PORTS  forward source valid per port.
REQ-017 SHALL have port fwd_stage_o  output  READ_PORTS*SW  youngest matching stage per port.
REQ-018 SHALL have port pending_o  output  clog2(DEPTH+1)  count of valid entries.

Function
REQ-019 SHALL hold DEPTH registered entries {valid, waddr, late}; stage 0 is youngest (EX), stage DEPTH-1 oldest.
REQ-020 SHALL treat address 0 as never hazardous; an issue with waddr 0 or issue_we_i=0 inserts an invalid entry.
REQ-021 SHALL match port p at stage k when rd_en_i[p], rd_addr_p != 0, entry k valid and waddr equal; youngest (lowest k) match wins.
REQ-022 SHALL compute stall_o, fwd_hit_o, fwd_stage_o combinationally from current inputs and state (zero-cycle latency).
REQ-023 SHALL, without forwarding, assert stall_o when issue_valid_i and any port matches any stage.
REQ-024 SHALL, each edge with flush_i=0 and hold_i=0, shift entries k->k+1, drop entry DEPTH-1 (regfile writes it that cycle with write-before-read), and load stage 0 with the issue entry, or with an invalid bubble when stall_o=1 or issue_valid_i=0.
REQ-025 SHALL leave all entries unchanged on an edge with hold_i=1 and flush_i=0.
REQ-026 SHALL invalidate all entries on an edge with flush_i=1, regardless of hold_i or issue.
REQ-027 SHALL drive pending_o as the registered population count of valid entries, updated on the same edge as the entries.
REQ-028 SHALL, when DEPTH=1, retire every entry after one cycle and make stage 0 the only forward source.

Reset
REQ-029 SHALL on rst=1 immediately invalidate all entries and force stall_o=0, fwd_hit_o=0, fwd_stage_o=0, pending_o=0.
REQ-030 SHALL, on rst asserted mid-stall, resume after deassertion with an empty scoreboard and no stall.

Configuration
REQ-031 SHALL support macro SCOREBOARD_FWD_EN; when defined, fwd_hit_o[p] equals the port match, fwd_stage_o gives the youngest stage, and stall_o asserts only when the youngest match is at stage 0 with late=1.
REQ-032 SHALL, when SCOREBOARD_FWD_EN is undefined, tie fwd_hit_o and fwd_stage_o to 0 and stall per REQ-023.

Structure
REQ-033 SHALL place the entry record typedef, SW/count width functions and stage-index constants in the shared pipeline package.
REQ-034 SHALL use one sub-module, sb_match, instantiated per read port, returning hit and youngest stage index.

Verification
REQ-035 SHALL cover: rst asserted with state full -> all outputs 0 in the same cycle, pending_o=0.
REQ-036 SHALL cover (no FWD, DEPTH=3): issue waddr=5, next cycle read r5 -> stall_o=1 for 3 cycles, then 0; pending_o 1,1,1,0.
REQ-037 SHALL cover (FWD): issue waddr=7 late=0, next cycle read r7 -> stall_o=0, fwd_hit=1, fwd_stage=0; late=1 -> one stall cycle then fwd_stage=1.
REQ-038 SHALL cover: waddr=5 at stages 0 and 2, read r5 -> fwd_stage=0 (youngest wins); read r0 -> no hit.
REQ-039 SHALL cover: hold_i=1 for 4 cycles with pending_o=2 -> entries and pending_o unchanged; flush_i with hold_i=1 -> pending_o=0 next cycle.
REQ-040 SHALL cover: issue_we_i=0 or waddr=0 -> pending_o unchanged at 0, no stall on later reads.
